discrete_output_driver: RTL and testbench
=========================================

// Module: discrete_output_driver
// PURPOSE
//   Drives NUMBER_SIGNALS discrete outputs (relay or valve drives) from raw command bits.
//   Each channel has its own state machine that enforces a minimum dwell between output edges
//   and verifies each edge through a readback input.
//   On a readback fault the channel is forced to its safe state and latched there until the
//   host clears it.
//   Sits on the output side of the actuator electronics; readback_i arrives already debounced.
// PARAMETERS
//   NUMBER_SIGNALS      4          number of independent channels
//   CLOCK_PERIOD_NS     20         clk_i period, ns
//   MIN_DWELL_NS        500_000    minimum time between two edges on one output, ns
//   READBACK_TIMEOUT_NS 100_000    maximum readback lag after an edge, ns
//   SAFE_STATE          '1         per-channel output level at reset and in FAULT
// PORTS
//   clk_i          input   1  single clock; all logic on posedge
//   reset_i        input   1  synchronous, active-high reset
//   command_i      input   N  requested output levels
//   readback_i     input   N  filtered readback of the driven lines
//   fault_clear_i  input   N  1-cycle pulse; per channel, leaves FAULT
//   outputs_o      output  N  driven levels, registered
//   busy_o         output  N  1 while the channel is in WAIT_DWELL or SWITCH
//   fault_o        output  N  1 while the channel is in FAULT
// BEHAVIOUR
//   Derived constants:
//     DWELL = MIN_DWELL_NS/CLOCK_PERIOD_NS cycles.
//     TMO = READBACK_TIMEOUT_NS/CLOCK_PERIOD_NS cycles.
//     Counters are $clog2(max+1) bits wide and saturate at their max value (no wrap).
//   Reset: outputs_o=SAFE_STATE, busy_o=0, fault_o=0, every channel in IDLE, all counters=0.
//     The dwell is therefore not yet satisfied after reset.
//   Per-channel FSM {IDLE, WAIT_DWELL, SWITCH, FAULT}:
//     dwell_cnt counts cycles since the last output edge or since reset.
//     IDLE, command==output: stay in IDLE.
//       If readback!=output for TMO consecutive cycles -> FAULT (stuck line).
//     IDLE, command!=output, dwell_cnt>=DWELL: toggle output on this edge (1-cycle latency),
//       clear dwell_cnt and chk_cnt -> SWITCH.
//     IDLE, command!=output, dwell_cnt<DWELL: -> WAIT_DWELL.
//     WAIT_DWELL: if command returns to the output level -> IDLE with no edge.
//       When dwell_cnt reaches DWELL: toggle, clear counters -> SWITCH.
//     SWITCH: chk_cnt increments each cycle; dwell_cnt keeps counting.
//       readback==output -> IDLE.
//       chk_cnt==TMO with no match -> FAULT.
//       Command changes are ignored until the channel leaves SWITCH.
//     FAULT: outputs_o=SAFE_STATE on the entry edge and while in FAULT; readback is ignored.
//       fault_clear_i -> IDLE with dwell_cnt cleared.
//   fault_clear_i outside FAULT is ignored.
//   Entering FAULT when the output is already at SAFE_STATE produces no edge.
//   A SWITCH toggle is still a counted edge for dwell purposes.
//   Channels are fully independent; simultaneous events on different channels do not interact.
//   reset_i asserted mid-SWITCH or in FAULT overrides everything and restores the reset state
//     on the next edge.
//   busy_o and fault_o decode the state register (no extra latency vs state).
// TESTING
//   Overrides: CLOCK_PERIOD_NS=20, MIN_DWELL_NS=200 (DWELL=10), READBACK_TIMEOUT_NS=100 (TMO=5),
//   SAFE_STATE=4'b1111, readback_i modelled as outputs_o delayed 2 cycles unless noted.
//   1. Release reset, command_i=4'b1110 at cycle 0.
//      -> out[0]=1 and busy_o[0]=1 until dwell_cnt=10.
//      -> out[0]=0 on the next edge; busy_o[0]=0 two cycles later; fault_o=0.
//   2. After test 1, settle, then pulse cmd[0]=1 for 3 cycles back to 0, issued 4 cycles after
//      the edge.
//      -> WAIT_DWELL then IDLE; out[0] stays 0 with no edge.
//   3. readback[1] held at 1 after out[1] drops to 0.
//      -> fault_o[1]=1 and out[1]=1 exactly 5 cycles after the edge; other channels unaffected.
//   4. While in FAULT, cmd[1]=0 with no fault_clear.
//      -> out[1] stays 1.
//      Pulse fault_clear_i[1] with readback restored.
//      -> IDLE; out[1]=0 10 cycles later.
//   5. IDLE with out[2]=1, force readback[2]=0.
//      -> fault_o[2]=1 after 5 cycles; no output edge.
//   6. Assert reset_i for 1 cycle during SWITCH on all channels.
//      -> next edge: outputs_o=4'b1111, busy_o=0, fault_o=0; first new edge no earlier than 10
//         cycles after reset.

Source files
------------

// File: rtl/discrete_output_driver.sv
// rtl/discrete_output_driver.sv - per-channel discrete output driver with dwell enforcement and readback checking
module discrete_output_driver #(
  parameter int                        NUMBER_SIGNALS      = 4,
  parameter int                        CLOCK_PERIOD_NS     = 20,
  parameter int                        MIN_DWELL_NS        = 500_000,
  parameter int                        READBACK_TIMEOUT_NS = 100_000,
  parameter logic [NUMBER_SIGNALS-1:0] SAFE_STATE          = '1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [NUMBER_SIGNALS-1:0] command_i,
  input  logic [NUMBER_SIGNALS-1:0] readback_i,
  input  logic [NUMBER_SIGNALS-1:0] fault_clear_i,
  output logic [NUMBER_SIGNALS-1:0] outputs_o,
  output logic [NUMBER_SIGNALS-1:0] busy_o,
  output logic [NUMBER_SIGNALS-1:0] fault_o
);

  localparam int DWELL = MIN_DWELL_NS / CLOCK_PERIOD_NS;
  localparam int TMO   = READBACK_TIMEOUT_NS / CLOCK_PERIOD_NS;
  localparam int DW    = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
  localparam int CW    = (TMO < 1) ? 1 : $clog2(TMO + 1);

  localparam logic [DW-1:0] DWELL_C = DW'(DWELL);
  localparam logic [CW-1:0] TMO_C   = CW'(TMO);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DWELL = 2'd1,
    SWITCH     = 2'd2,
    FAULT      = 2'd3
  } state_e;

  for (genvar g = 0; g < NUMBER_SIGNALS; g++) begin : g_ch
    state_e          state_q, state_d;
    logic            out_q, out_d;
    logic [DW-1:0]   dwell_q, dwell_d, dwell_inc;
    logic [CW-1:0]   chk_q, chk_d, chk_inc;
    logic            dwell_ok, cmd_diff, rb_match;

    always_comb begin
      dwell_inc = (dwell_q == DWELL_C) ? dwell_q : dwell_q + 1'b1;
      chk_inc   = (chk_q == TMO_C) ? chk_q : chk_q + 1'b1;
      dwell_ok  = (dwell_q >= DWELL_C);
      cmd_diff  = (command_i[g] != out_q);
      rb_match  = (readback_i[g] == out_q);
      state_d   = state_q;
      out_d     = out_q;
      dwell_d   = dwell_inc;
      chk_d     = chk_q;

      case (state_q)
        IDLE: begin
          if (cmd_diff) begin
            chk_d = '0;
            if (dwell_ok) begin
              out_d   = ~out_q;
              state_d = SWITCH;
            end else begin
              state_d = WAIT_DWELL;
            end
          end else if (!rb_match) begin
            // A steady line whose readback disagrees long enough is treated as stuck.
            chk_d = chk_inc;
            if (chk_inc >= TMO_C) begin
              state_d = FAULT;
              out_d   = SAFE_STATE[g];
              chk_d   = '0;
            end
          end else begin
            chk_d = '0;
          end
        end
        WAIT_DWELL: begin
          if (!cmd_diff) begin
            state_d = IDLE;
          end else if (dwell_ok) begin
            out_d   = ~out_q;
            chk_d   = '0;
            state_d = SWITCH;
          end
        end
        SWITCH: begin
          if (rb_match) begin
            chk_d   = '0;
            state_d = IDLE;
          end else begin
            chk_d = chk_inc;
            if (chk_inc >= TMO_C) begin
              state_d = FAULT;
              out_d   = SAFE_STATE[g];
              chk_d   = '0;
            end
          end
        end
        FAULT: begin
          out_d = SAFE_STATE[g];
          chk_d = '0;
          if (fault_clear_i[g]) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          out_d   = SAFE_STATE[g];
        end
      endcase

      // Any edge on the line, or leaving FAULT, restarts the dwell window.
      if ((out_d != out_q) || (state_q == FAULT && state_d == IDLE)) begin
        dwell_d = '0;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        state_q <= IDLE;
        out_q   <= SAFE_STATE[g];
        dwell_q <= '0;
        chk_q   <= '0;
      end else begin
        state_q <= state_d;
        out_q   <= out_d;
        dwell_q <= dwell_d;
        chk_q   <= chk_d;
      end
    end

    assign outputs_o[g] = out_q;
    assign busy_o[g]    = (state_q == WAIT_DWELL) || (state_q == SWITCH);
    assign fault_o[g]   = (state_q == FAULT);
  end

endmodule

// File: tb/tb_discrete_output_driver.sv
// tb/tb_discrete_output_driver.sv - directed self-checking bench for discrete_output_driver
module tb_discrete_output_driver;

  logic       clk;
  logic       reset_i;
  logic [3:0] command_i;
  logic [3:0] readback_i;
  logic [3:0] fault_clear_i;
  logic [3:0] outputs_o;
  logic [3:0] busy_o;
  logic [3:0] fault_o;

  logic [3:0] prev_out;
  logic [3:0] rb_base;
  logic [3:0] force_mask;
  logic [3:0] force_val;
  int         errors;
  int         checks;

  discrete_output_driver #(
    .NUMBER_SIGNALS      (4),
    .CLOCK_PERIOD_NS     (20),
    .MIN_DWELL_NS        (200),
    .READBACK_TIMEOUT_NS (100),
    .SAFE_STATE          (4'b1111)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .command_i     (command_i),
    .readback_i    (readback_i),
    .fault_clear_i (fault_clear_i),
    .outputs_o     (outputs_o),
    .busy_o        (busy_o),
    .fault_o       (fault_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_rb();
    readback_i = (rb_base & ~force_mask) | (force_val & force_mask);
  endtask

  // Readback line lags the driven level: a change after edge E is seen by the DUT at edge E+2.
  task automatic tick();
    @(posedge clk);
    #1;
    rb_base  = prev_out;
    prev_out = outputs_o;
    apply_rb();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_i       = 1'b1;
    command_i     = 4'b1111;
    fault_clear_i = 4'b0000;
    prev_out      = 4'b1111;
    rb_base       = 4'b1111;
    force_mask    = 4'b0000;
    force_val     = 4'b0000;
    apply_rb();
    tick();
    tick();
    chk("reset_out", outputs_o, 4'b1111);
    chk("reset_busy", busy_o, 4'b0000);
    chk("reset_fault", fault_o, 4'b0000);

    // Test 1: dwell not yet satisfied after reset
    reset_i   = 1'b0;
    command_i = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t1_hold_out", outputs_o, 4'b1111);
      chk("t1_wait_busy", busy_o, 4'b0001);
    end
    tick();
    chk("t1_edge_out", outputs_o, 4'b1110);
    chk("t1_switch_busy", busy_o, 4'b0001);
    tick();
    chk("t1_switch_busy2", busy_o, 4'b0001);
    tick();
    chk("t1_idle_busy", busy_o, 4'b0000);
    chk("t1_fault", fault_o, 4'b0000);

    // Test 2: short command glitch inside the dwell window
    tick();
    tick();
    command_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_wait_busy", busy_o, 4'b0001);
      chk("t2_wait_out", outputs_o, 4'b1110);
    end
    command_i = 4'b1110;
    tick();
    chk("t2_idle_busy", busy_o, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t2_no_edge", outputs_o, 4'b1110);
    end

    fault_clear_i = 4'b0001;
    tick();
    fault_clear_i = 4'b0000;
    chk("clr_ignored_fault", fault_o, 4'b0000);
    chk("clr_ignored_busy", busy_o, 4'b0000);
    chk("clr_ignored_out", outputs_o, 4'b1110);

    // Test 3: readback[1] stuck high after a falling edge
    force_mask = 4'b0010;
    force_val  = 4'b0010;
    apply_rb();
    command_i = 4'b1100;
    tick();
    chk("t3_edge_out", outputs_o, 4'b1100);
    chk("t3_edge_busy", busy_o, 4'b0010);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t3_pre_fault", fault_o, 4'b0000);
      chk("t3_pre_out", outputs_o, 4'b1100);
    end
    tick();
    chk("t3_fault", fault_o, 4'b0010);
    chk("t3_safe_out", outputs_o, 4'b1110);
    chk("t3_busy", busy_o, 4'b0000);

    // Test 4: FAULT is latched until cleared
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_latched_out", outputs_o, 4'b1110);
      chk("t4_latched_fault", fault_o, 4'b0010);
    end
    force_mask = 4'b0000;
    apply_rb();
    fault_clear_i = 4'b0010;
    tick();
    fault_clear_i = 4'b0000;
    chk("t4_cleared_fault", fault_o, 4'b0000);
    chk("t4_cleared_out", outputs_o, 4'b1110);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t4_dwell_out", outputs_o, 4'b1110);
      chk("t4_dwell_busy", busy_o, 4'b0010);
    end
    tick();
    chk("t4_edge_out", outputs_o, 4'b1100);
    tick();
    tick();
    chk("t4_idle_busy", busy_o, 4'b0000);
    chk("t4_fault", fault_o, 4'b0000);

    // Test 5: stuck readback on a steady line
    force_mask = 4'b0100;
    force_val  = 4'b0000;
    apply_rb();
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t5_pre_fault", fault_o, 4'b0000);
    end
    tick();
    chk("t5_fault", fault_o, 4'b0100);
    chk("t5_no_edge", outputs_o, 4'b1100);
    force_mask    = 4'b0000;
    apply_rb();
    fault_clear_i = 4'b0100;
    tick();
    fault_clear_i = 4'b0000;
    chk("t5_cleared", fault_o, 4'b0000);

    // Test 6: reset in the middle of SWITCH on every channel
    for (int k = 0; k < 12; k++) tick();
    chk("t6_pre_out", outputs_o, 4'b1100);
    command_i = 4'b0011;
    tick();
    chk("t6_switch_out", outputs_o, 4'b0011);
    chk("t6_switch_busy", busy_o, 4'b1111);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("t6_reset_out", outputs_o, 4'b1111);
    chk("t6_reset_busy", busy_o, 4'b0000);
    chk("t6_reset_fault", fault_o, 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t6_dwell_out", outputs_o, 4'b1111);
      chk("t6_dwell_busy", busy_o, 4'b1100);
    end
    tick();
    chk("t6_edge_out", outputs_o, 4'b0011);
    tick();
    tick();
    chk("t6_idle_busy", busy_o, 4'b0000);
    chk("t6_fault", fault_o, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
